// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bit-level command encodings used by both the byte
// and bit controllers, and the byte sequencer state encoding.
package i2c_pkg;

    localparam logic [3:0] I2C_CMD_NOP   = 4'b0000;
    localparam logic [3:0] I2C_CMD_START = 4'b0001;
    localparam logic [3:0] I2C_CMD_STOP  = 4'b0010;
    localparam logic [3:0] I2C_CMD_WRITE = 4'b0100;
    localparam logic [3:0] I2C_CMD_READ  = 4'b1000;

    localparam int unsigned I2C_BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_ACK   = 3'd4,
        ST_STOP  = 3'd5
    } byte_state_t;

endpackage

// File: rtl/i2c_master_byte_ctrl_if.sv
// Host-side and bit-controller-side signals of the I2C byte sequencer.
// The master modport is the byte controller's view; slave is its environment.
interface i2c_master_byte_ctrl_if;
    import i2c_pkg::*;

    logic                  start;
    logic                  stop;
    logic                  read;
    logic                  write;
    logic                  ack_in;
    logic [I2C_BYTE_W-1:0] din;
    logic                  cmd_ack;
    logic                  ack_out;
    logic [I2C_BYTE_W-1:0] dout;
    logic                  i2c_busy;
    logic                  i2c_al;

    logic [3:0]            core_cmd;
    logic                  core_txd;
    logic                  core_ack;
    logic                  core_rxd;
    logic                  bit_al;
    logic                  bit_busy;

    modport master (
        input  start, stop, read, write, ack_in, din,
        output cmd_ack, ack_out, dout, i2c_busy, i2c_al,
        output core_cmd, core_txd,
        input  core_ack, core_rxd, bit_al, bit_busy
    );

    modport slave (
        output start, stop, read, write, ack_in, din,
        input  cmd_ack, ack_out, dout, i2c_busy, i2c_al,
        input  core_cmd, core_txd,
        output core_ack, core_rxd, bit_al, bit_busy
    );

endinterface

// File: rtl/i2c_byte_shift.sv
// Byte shift register and bit counter: loads a byte to send, shifts MSB-first
// while capturing received bits into the LSB.
module i2c_byte_shift
    import i2c_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld,
    input  logic                  shift,
    input  logic [I2C_BYTE_W-1:0] din,
    input  logic                  rxd,
    output logic [I2C_BYTE_W-1:0] sr,
    output logic                  cnt_done
);

    logic [2:0] dcnt;

    // A fresh load always wins over a pending shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr   <= '0;
            dcnt <= 3'd0;
        end else if (ld) begin
            sr   <= din;
            dcnt <= 3'd7;
        end else if (shift) begin
            sr   <= {sr[I2C_BYTE_W-2:0], rxd};
            dcnt <= dcnt - 3'd1;
        end
    end

    assign cnt_done = (dcnt == 3'd0);

endmodule

// File: rtl/i2c_master_byte_ctrl.sv
// I2C byte command sequencer: turns host start/write/read/stop requests into
// bit-level commands for the bit controller and handles the acknowledge bit.
module i2c_master_byte_ctrl
    import i2c_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    i2c_master_byte_ctrl_if.master bus
);

    byte_state_t           state, state_nxt;
    logic [3:0]            core_cmd_q, core_cmd_nxt;
    logic                  core_txd_q, core_txd_nxt;
    logic                  cmd_ack_q, cmd_ack_nxt;
    logic                  ack_out_q, ack_out_nxt;
    logic                  ld, shift;
    logic                  cnt_done;
    logic                  go;
    logic [I2C_BYTE_W-1:0] sr;

    i2c_byte_shift u_shift (
        .clk      (clk),
        .rst      (rst),
        .ld       (ld),
        .shift    (shift),
        .din      (bus.din),
        .rxd      (bus.core_rxd),
        .sr       (sr),
        .cnt_done (cnt_done)
    );

    // Masking with cmd_ack stops a still-held command from restarting.
    assign go = (bus.read | bus.write | bus.stop) & ~cmd_ack_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            core_cmd_q <= I2C_CMD_NOP;
            core_txd_q <= 1'b0;
            cmd_ack_q  <= 1'b0;
            ack_out_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            core_cmd_q <= core_cmd_nxt;
            core_txd_q <= core_txd_nxt;
            cmd_ack_q  <= cmd_ack_nxt;
            ack_out_q  <= ack_out_nxt;
        end
    end

    // Lost arbitration drops everything back to idle ahead of any transition;
    // the shift register and counter are left as they were.
    always_comb begin
        state_nxt    = state;
        core_cmd_nxt = core_cmd_q;
        core_txd_nxt = sr[I2C_BYTE_W-1];
        cmd_ack_nxt  = 1'b0;
        ack_out_nxt  = ack_out_q;
        ld           = 1'b0;
        shift        = 1'b0;

        if (bus.bit_al) begin
            state_nxt    = ST_IDLE;
            core_cmd_nxt = I2C_CMD_NOP;
            core_txd_nxt = 1'b0;
            ack_out_nxt  = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        ld = 1'b1;
                        if (bus.start) begin
                            state_nxt    = ST_START;
                            core_cmd_nxt = I2C_CMD_START;
                        end else if (bus.read) begin
                            state_nxt    = ST_READ;
                            core_cmd_nxt = I2C_CMD_READ;
                        end else if (bus.write) begin
                            state_nxt    = ST_WRITE;
                            core_cmd_nxt = I2C_CMD_WRITE;
                        end else begin
                            state_nxt    = ST_STOP;
                            core_cmd_nxt = I2C_CMD_STOP;
                        end
                    end
                end

                ST_START: begin
                    if (bus.core_ack) begin
                        ld = 1'b1;
                        if (bus.read) begin
                            state_nxt    = ST_READ;
                            core_cmd_nxt = I2C_CMD_READ;
                        end else begin
                            state_nxt    = ST_WRITE;
                            core_cmd_nxt = I2C_CMD_WRITE;
                        end
                    end
                end

                ST_WRITE: begin
                    if (bus.core_ack) begin
                        if (cnt_done) begin
                            state_nxt    = ST_ACK;
                            core_cmd_nxt = I2C_CMD_READ;
                        end else begin
                            core_cmd_nxt = I2C_CMD_WRITE;
                            shift        = 1'b1;
                        end
                    end
                end

                // The master drives its own ACK/NACK level while reading.
                ST_READ: begin
                    core_txd_nxt = bus.ack_in;
                    if (bus.core_ack) begin
                        shift = 1'b1;
                        if (cnt_done) begin
                            state_nxt    = ST_ACK;
                            core_cmd_nxt = I2C_CMD_WRITE;
                        end else begin
                            core_cmd_nxt = I2C_CMD_READ;
                        end
                    end
                end

                ST_ACK: begin
                    if (bus.core_ack) begin
                        ack_out_nxt  = bus.core_rxd;
                        core_txd_nxt = 1'b1;
                        if (bus.stop) begin
                            state_nxt    = ST_STOP;
                            core_cmd_nxt = I2C_CMD_STOP;
                        end else begin
                            state_nxt    = ST_IDLE;
                            core_cmd_nxt = I2C_CMD_NOP;
                            cmd_ack_nxt  = 1'b1;
                        end
                    end else begin
                        core_txd_nxt = bus.ack_in;
                    end
                end

                ST_STOP: begin
                    if (bus.core_ack) begin
                        state_nxt    = ST_IDLE;
                        core_cmd_nxt = I2C_CMD_NOP;
                        cmd_ack_nxt  = 1'b1;
                    end
                end

                default: begin
                    state_nxt    = ST_IDLE;
                    core_cmd_nxt = I2C_CMD_NOP;
                end
            endcase
        end
    end

    assign bus.core_cmd = core_cmd_q;
    assign bus.core_txd = core_txd_q;
    assign bus.cmd_ack  = cmd_ack_q;
    assign bus.ack_out  = ack_out_q;
    assign bus.dout     = sr;
    assign bus.i2c_busy = bus.bit_busy;
    assign bus.i2c_al   = bus.bit_al;

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Testbench for i2c_master_byte_ctrl: a behavioural bit controller answers each
// bit command and a scoreboard compares issued commands against expectations.
module tb_i2c_master_byte_ctrl;
    import i2c_pkg::*;

    typedef struct {
        logic [3:0] cmd;
        logic       chk_txd;
        logic       txd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    i2c_master_byte_ctrl_if bus ();

    i2c_master_byte_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    logic rxd_q[$];
    exp_t exp_item;
    int   tests_run      = 0;
    int   tests_failed   = 0;
    int   cycle          = 0;
    int   last_ack_cycle = -10;
    int   cmd_ack_cnt    = 0;
    int   done_cnt       = 0;
    int   stop_cnt       = 0;
    int   busy_cnt       = 0;
    logic model_busy     = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    // Bit controller model: accepts a command, acks it 4 clocks later, and
    // scores the command (and transmitted bit) at the ack.
    always @(negedge clk) begin
        if (bus.cmd_ack) begin
            cmd_ack_cnt++;
            checkOutput("cmd_ack_latency", 32'(cycle - last_ack_cycle), 32'd1);
        end
        bus.core_ack = 1'b0;
        if (rst || bus.bit_al) begin
            model_busy = 1'b0;
        end else if (model_busy) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                model_busy     = 1'b0;
                bus.core_ack   = 1'b1;
                last_ack_cycle = cycle;
                done_cnt++;
                if (bus.core_cmd == I2C_CMD_READ) begin
                    if (rxd_q.size() > 0) bus.core_rxd = rxd_q.pop_front();
                    else                  bus.core_rxd = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    checkOutput("extra_cmd", 32'(bus.core_cmd), 32'(I2C_CMD_NOP));
                end else begin
                    exp_item = exp_q.pop_front();
                    checkOutput("core_cmd", 32'(bus.core_cmd), 32'(exp_item.cmd));
                    if (exp_item.chk_txd)
                        checkOutput("core_txd", 32'(bus.core_txd), 32'(exp_item.txd));
                end
            end
        end else if (bus.core_cmd != I2C_CMD_NOP) begin
            model_busy = 1'b1;
            busy_cnt   = 4;
            if (bus.core_cmd == I2C_CMD_STOP) stop_cnt++;
        end
    end

    task automatic clearHost();
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.read   = 1'b0;
        bus.write  = 1'b0;
        bus.ack_in = 1'b0;
        bus.din    = 8'h00;
    endtask

    // Drives a host command and queues the bit commands it should produce.
    task automatic applyStimulus(input logic s, input logic p, input logic rd, input logic wr,
                                 input logic ai, input logic [7:0] d);
        bus.start  = s;
        bus.stop   = p;
        bus.read   = rd;
        bus.write  = wr;
        bus.ack_in = ai;
        bus.din    = d;
        if (s) exp_q.push_back('{I2C_CMD_START, 1'b0, 1'b0});
        if (rd) begin
            for (int i = 0; i < 8; i++) exp_q.push_back('{I2C_CMD_READ, 1'b1, ai});
            exp_q.push_back('{I2C_CMD_WRITE, 1'b1, ai});
        end else if (wr) begin
            for (int i = 7; i >= 0; i--) exp_q.push_back('{I2C_CMD_WRITE, 1'b1, d[i]});
            exp_q.push_back('{I2C_CMD_READ, 1'b0, 1'b0});
        end
        if (p) exp_q.push_back('{I2C_CMD_STOP, 1'b0, 1'b0});
    endtask

    // Holds the command through its cmd_ack cycle, then drops it.
    task automatic waitCmdAck(input int budget);
        int n = 0;
        while (!bus.cmd_ack && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (!bus.cmd_ack) checkOutput("cmd_ack_timeout", 32'(bus.cmd_ack), 32'd1);
        else begin
            @(negedge clk); #1;
        end
        clearHost();
    endtask

    task automatic waitDone(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (done_cnt < target) checkOutput("done_timeout", 32'(done_cnt), 32'(target));
    endtask

    task automatic flushModel();
        exp_q.delete();
        rxd_q.delete();
    endtask

    int c0, s0, d0;

    initial begin
        clearHost();
        bus.core_ack = 1'b0;
        bus.core_rxd = 1'b0;
        bus.bit_al   = 1'b0;
        bus.bit_busy = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_core_cmd", 32'(bus.core_cmd), 32'(I2C_CMD_NOP));
        checkOutput("rst_core_txd", 32'(bus.core_txd), 32'd0);
        checkOutput("rst_cmd_ack", 32'(bus.cmd_ack), 32'd0);
        checkOutput("rst_ack_out", 32'(bus.ack_out), 32'd0);
        checkOutput("rst_dout", 32'(bus.dout), 32'd0);
        checkOutput("rst_state", 32'(dut.state), 32'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk); #1;

        // start + write A5 + stop, slave ACKs
        c0 = cmd_ack_cnt; s0 = stop_cnt;
        rxd_q.push_back(1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5);
        waitCmdAck(200);
        checkOutput("wr_ack_out", 32'(bus.ack_out), 32'd0);
        checkOutput("wr_cmd_ack_cnt", 32'(cmd_ack_cnt - c0), 32'd1);
        checkOutput("wr_stop_cnt", 32'(stop_cnt - s0), 32'd1);
        checkOutput("wr_q_left", 32'(exp_q.size()), 32'd0);

        // read with NACK, bits 0,1,1,0,1,0,0,1
        c0 = cmd_ack_cnt; s0 = stop_cnt;
        foreach (rxd_q[i]) rxd_q.delete(i);
        rxd_q = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        waitCmdAck(200);
        checkOutput("rd_dout", 32'(bus.dout), 32'h69);
        checkOutput("rd_cmd_ack_cnt", 32'(cmd_ack_cnt - c0), 32'd1);
        checkOutput("rd_no_stop", 32'(stop_cnt - s0), 32'd0);
        checkOutput("rd_q_left", 32'(exp_q.size()), 32'd0);

        // write 00 without start/stop, slave NACKs
        c0 = cmd_ack_cnt;
        rxd_q.push_back(1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        waitCmdAck(200);
        checkOutput("nack_ack_out", 32'(bus.ack_out), 32'd1);
        checkOutput("nack_cmd_ack_cnt", 32'(cmd_ack_cnt - c0), 32'd1);
        checkOutput("nack_state", 32'(dut.state), 32'(ST_IDLE));
        checkOutput("nack_core_cmd", 32'(bus.core_cmd), 32'(I2C_CMD_NOP));

        // asynchronous reset in the middle of a read
        d0 = done_cnt;
        rxd_q = '{1'b1, 1'b1, 1'b1};
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        waitDone(d0 + 3, 100);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_core_cmd", 32'(bus.core_cmd), 32'(I2C_CMD_NOP));
        checkOutput("arst_core_txd", 32'(bus.core_txd), 32'd0);
        checkOutput("arst_ack_out", 32'(bus.ack_out), 32'd0);
        checkOutput("arst_dout", 32'(bus.dout), 32'd0);
        checkOutput("arst_state", 32'(dut.state), 32'(ST_IDLE));
        clearHost();
        flushModel();
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        c0 = cmd_ack_cnt;
        rxd_q.push_back(1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C);
        waitCmdAck(200);
        checkOutput("post_rst_cmd_ack_cnt", 32'(cmd_ack_cnt - c0), 32'd1);
        checkOutput("post_rst_q_left", 32'(exp_q.size()), 32'd0);

        // arbitration lost during the 4th write bit
        c0 = cmd_ack_cnt; d0 = done_cnt;
        bus.bit_busy = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF);
        waitDone(d0 + 3, 100);
        @(negedge clk); #1;
        checkOutput("busy_passthru", 32'(bus.i2c_busy), 32'd1);
        bus.bit_al = 1'b1;
        @(negedge clk); #1;
        checkOutput("al_core_cmd", 32'(bus.core_cmd), 32'(I2C_CMD_NOP));
        checkOutput("al_core_txd", 32'(bus.core_txd), 32'd0);
        checkOutput("al_state", 32'(dut.state), 32'(ST_IDLE));
        checkOutput("al_i2c_al", 32'(bus.i2c_al), 32'd1);
        clearHost();
        bus.bit_al   = 1'b0;
        bus.bit_busy = 1'b0;
        flushModel();
        repeat (8) @(negedge clk);
        #1;
        checkOutput("al_no_cmd_ack", 32'(cmd_ack_cnt - c0), 32'd0);
        checkOutput("al_i2c_al_clr", 32'(bus.i2c_al), 32'd0);

        // stop-only command held through its cmd_ack cycle
        c0 = cmd_ack_cnt; s0 = stop_cnt;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        waitCmdAck(20);
        repeat (12) @(negedge clk);
        #1;
        checkOutput("stop_only_cnt", 32'(stop_cnt - s0), 32'd1);
        checkOutput("stop_only_cmd_ack", 32'(cmd_ack_cnt - c0), 32'd1);
        checkOutput("stop_only_q_left", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
